// File: rtl/acc_program_sequencer.sv
// Program sequencer for the 8-bit accumulator datapath.
// Holds a byte-loaded program RAM, fetches and decodes instructions, issues
// ALU ops over a valid/ready handshake and handles NOP/JMP/JNZ/HALT locally.
module acc_program_sequencer #(
  parameter int unsigned AW         = 4,
  parameter int unsigned STEP_LIMIT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  input  logic          start,
  input  logic          acc_zero,
  output logic          op_valid,
  output logic [3:0]    op_code,
  output logic [3:0]    op_data,
  input  logic          op_ready,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam logic [7:0]  STEP_MAX = 8'(STEP_LIMIT);
  localparam logic [3:0]  OP_JMP   = 4'h6;
  localparam logic [3:0]  OP_JNZ   = 4'h7;
  localparam logic [3:0]  OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]    step_cnt_q, step_cnt_d;
  logic [7:0]    ir_q, ir_d;
  logic          op_valid_q, op_valid_d;
  logic [3:0]    op_code_q, op_code_d;
  logic [3:0]    op_data_q, op_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          load_ready_q, load_ready_d;

  logic [7:0]    mem [DEPTH];
  logic          mem_we;
  logic [7:0]    fetch_word;
  logic          fetch_is_alu;
  logic          complete;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] jump_target;

  assign fetch_word   = mem[pc_q];
  assign fetch_is_alu = (fetch_word[3:0] >= 4'd1) && (fetch_word[3:0] <= 4'd5);
  assign jump_target  = AW'(ir_q[7:4]);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    wr_ptr_d     = wr_ptr_q;
    step_cnt_d   = step_cnt_q;
    ir_d         = ir_q;
    op_valid_d   = op_valid_q;
    op_code_d    = op_code_q;
    op_data_d    = op_data_q;
    done_d       = done_q;
    error_d      = error_q;
    mem_we       = 1'b0;
    complete     = 1'b0;
    pc_next      = pc_q + AW'(1);

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // A load handshake takes priority over a simultaneous start
        if (load_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
        end else if (start) begin
          pc_d       = '0;
          step_cnt_d = '0;
          wr_ptr_d   = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = fetch_word;
        state_d = S_EXEC;
        if (fetch_is_alu) begin
          op_valid_d = 1'b1;
          op_code_d  = fetch_word[3:0];
          op_data_d  = fetch_word[7:4];
        end
      end
      S_EXEC: begin
        case (ir_q[3:0])
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            if (op_ready) begin
              complete   = 1'b1;
              op_valid_d = 1'b0;
            end
          end
          OP_JMP: begin
            complete = 1'b1;
            pc_next  = jump_target;
          end
          OP_JNZ: begin
            complete = 1'b1;
            if (!acc_zero) pc_next = jump_target;
          end
          OP_HALT: begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
          default: complete = 1'b1;
        endcase
        if (complete) begin
          pc_d       = pc_next;
          step_cnt_d = step_cnt_q + 8'd1;
          if ((step_cnt_q + 8'd1) == STEP_MAX) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d       = (state_d == S_FETCH) || (state_d == S_EXEC);
    load_ready_d = !busy_d;
  end

  // State and output registers; ena low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      wr_ptr_q     <= '0;
      step_cnt_q   <= '0;
      ir_q         <= '0;
      op_valid_q   <= 1'b0;
      op_code_q    <= '0;
      op_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      load_ready_q <= 1'b1;
    end else if (ena) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wr_ptr_q     <= wr_ptr_d;
      step_cnt_q   <= step_cnt_d;
      ir_q         <= ir_d;
      op_valid_q   <= op_valid_d;
      op_code_q    <= op_code_d;
      op_data_q    <= op_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      load_ready_q <= load_ready_d;
    end
  end

  // Program RAM write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (ena && !rst && mem_we) mem[wr_ptr_q] <= load_data;
  end

  assign load_ready = load_ready_q;
  assign op_valid   = op_valid_q;
  assign op_code    = op_code_q;
  assign op_data    = op_data_q;
  assign pc         = pc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_acc_program_sequencer.sv
// Scoreboard bench for acc_program_sequencer: expected ALU ops are queued by
// the stimulus and checked by an independent monitor on every op_valid cycle.
module tb_acc_program_sequencer;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b1;
  logic          load_valid = 1'b0;
  logic [7:0]    load_data = '0;
  logic          load_ready;
  logic          start = 1'b0;
  logic          acc_zero = 1'b0;
  logic          op_valid;
  logic [3:0]    op_code;
  logic [3:0]    op_data;
  logic          op_ready = 1'b1;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  acc_program_sequencer #(.AW(AW), .STEP_LIMIT(255)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .start(start), .acc_zero(acc_zero),
    .op_valid(op_valid), .op_code(op_code), .op_data(op_data), .op_ready(op_ready),
    .pc(pc), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  // Monitor: every offered op must match the scoreboard head; pop on handshake
  always @(negedge clk) begin
    if (op_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL op_unexpected actual=%0h/%0h expected=none", op_code, op_data);
      end else begin
        check("op_payload", 32'({op_code, op_data}), 32'(exp_q[0]));
        if (op_ready && ena && !rst) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_data  = b;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 2: op_ready low until cycle 4; mode 3: acc_zero rises at cycle 4
  task automatic run_until(input string nm, input int limit, input int mode, output int n);
    n = 0;
    while (!(done || error) && n < limit) begin
      tick();
      n++;
      if (mode == 2) op_ready = (n >= 4);
      if (mode == 3) begin
        acc_zero = (n >= 4);
        if (n == 4) check({nm, "_pc_after_jnz"}, 32'(pc), 32'd1);
        if (n == 6) check({nm, "_pc_fallthrough"}, 32'(pc), 32'd2);
      end
    end
    if (!(done || error)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=running expected=stopped within %0d", nm, limit);
    end
  endtask

  initial begin
    int n;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);

    // T1: ADD 3, SUB 2, HALT with op_ready tied high
    load_byte(8'h31);
    load_byte(8'h22);
    load_byte(8'h0F);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h22);
    op_ready = 1'b1;
    pulse_start();
    check("t1_busy_start", 32'(busy), 32'd1);
    check("t1_ready_low", 32'(load_ready), 32'd0);
    run_until("t1", 50, 0, n);
    check("t1_cycles", 32'(n), 32'd6);
    check("t1_done", 32'(done), 32'd1);
    check("t1_pc", 32'(pc), 32'd2);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_queue", 32'(exp_q.size()), 32'd0);

    // T2: same program, first op stalled 3 cycles
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h22);
    op_ready = 1'b0;
    pulse_start();
    check("t2_done_cleared", 32'(done), 32'd0);
    run_until("t2", 50, 2, n);
    check("t2_cycles", 32'(n), 32'd9);
    check("t2_done", 32'(done), 32'd1);
    check("t2_pc", 32'(pc), 32'd2);
    check("t2_queue", 32'(exp_q.size()), 32'd0);
    op_ready = 1'b1;

    // T3: ADD 2, JNZ 1 (taken once), HALT
    load_byte(8'h21);
    load_byte(8'h17);
    load_byte(8'hFF);
    exp_q.push_back(8'h12);
    acc_zero = 1'b0;
    pulse_start();
    run_until("t3", 50, 3, n);
    check("t3_cycles", 32'(n), 32'd8);
    check("t3_done", 32'(done), 32'd1);
    check("t3_error", 32'(error), 32'd0);
    check("t3_pc", 32'(pc), 32'd2);
    check("t3_queue", 32'(exp_q.size()), 32'd0);

    // T4: JMP 0 forever hits the step limit after 255 completions
    load_byte(8'h06);
    pulse_start();
    run_until("t4", 2000, 0, n);
    check("t4_cycles", 32'(n), 32'd510);
    check("t4_error", 32'(error), 32'd1);
    check("t4_done", 32'(done), 32'd0);
    check("t4_load_ready", 32'(load_ready), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_pc", 32'(pc), 32'd0);

    // T5: 17 bytes wrap wr_ptr; 17th (ADD 5) lands at address 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) load_byte(8'h0F);
    start = 1'b1;
    load_byte(8'h51);
    start = 1'b0;
    check("t5_start_ignored", 32'(busy), 32'd0);
    exp_q.push_back(8'h15);
    pulse_start();
    run_until("t5", 50, 0, n);
    check("t5_cycles", 32'(n), 32'd4);
    check("t5_pc", 32'(pc), 32'd1);
    check("t5_queue", 32'(exp_q.size()), 32'd0);

    // T6: ena low during a stalled ALU op, then reset mid-run
    exp_q.push_back(8'h15);
    op_ready = 1'b0;
    pulse_start();
    tick();
    check("t6_op_valid", 32'(op_valid), 32'd1);
    ena = 1'b0;
    op_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_hold_valid", 32'(op_valid), 32'd1);
      check("t6_hold_pc", 32'(pc), 32'd0);
      check("t6_hold_busy", 32'(busy), 32'd1);
    end
    op_ready = 1'b0;
    ena = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_op_valid", 32'(op_valid), 32'd0);
    check("t6_rst_pc", 32'(pc), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_error", 32'(error), 32'd0);
    check("t6_rst_load_ready", 32'(load_ready), 32'd1);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_op_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
